// File: rtl/clk_cfg_pkg.sv
// Shared types and constants for the clock-generator config initiator.
package clk_cfg_pkg;

  localparam int unsigned CFG_ADDR_W = 5;
  localparam int unsigned CFG_DATA_W = 32;

  localparam logic CFG_WRN_WRITE = 1'b0;
  localparam logic CFG_WRN_READ  = 1'b1;

  // Local register word offsets (PADDR[6:2] within the local domain)
  localparam logic [CFG_ADDR_W-1:0] LOC_STATUS  = 5'd0;
  localparam logic [CFG_ADDR_W-1:0] LOC_TIMEOUT = 5'd1;

  typedef enum logic [1:0] {
    DOM_SOC     = 2'd0,
    DOM_PER     = 2'd1,
    DOM_CLUSTER = 2'd2,
    DOM_LOCAL   = 2'd3
  } dom_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Status word layout: {26'b0, to_cluster, to_per, to_soc, cluster_lock, per_lock, soc_lock}
  function automatic logic [CFG_DATA_W-1:0] pack_status(input logic [2:0] to_flags,
                                                        input logic [2:0] locks);
    return {26'b0, to_flags, locks};
  endfunction

endpackage

// File: rtl/clk_cfg_timeout_cnt.sv
// Ack timeout counter: counts enabled cycles, flags expiry on the last one.
module clk_cfg_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Count while enabled, clear has priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/clk_cfg_initiator.sv
// APB slave turning register accesses into req/ack transactions on the
// soc/per/cluster clock-generator config ports, plus a local status space.
// Optional feature macro: CLK_CFG_TIMEOUT_EN (ack timeout, sticky flags, PSLVERR).
module clk_cfg_initiator
  import clk_cfg_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,

  output logic                      soc_cfg_req_o,
  input  logic                      soc_cfg_ack_i,
  input  logic                      soc_cfg_lock_i,
  input  logic [31:0]               soc_cfg_r_data_i,
  output logic [4:0]                soc_cfg_add_o,
  output logic [31:0]               soc_cfg_data_o,
  output logic                      soc_cfg_wrn_o,

  output logic                      per_cfg_req_o,
  input  logic                      per_cfg_ack_i,
  input  logic                      per_cfg_lock_i,
  input  logic [31:0]               per_cfg_r_data_i,
  output logic [4:0]                per_cfg_add_o,
  output logic [31:0]               per_cfg_data_o,
  output logic                      per_cfg_wrn_o,

  output logic                      cluster_cfg_req_o,
  input  logic                      cluster_cfg_ack_i,
  input  logic                      cluster_cfg_lock_i,
  input  logic [31:0]               cluster_cfg_r_data_i,
  output logic [4:0]                cluster_cfg_add_o,
  output logic [31:0]               cluster_cfg_data_o,
  output logic                      cluster_cfg_wrn_o
);

  state_e                 state_q, state_d;
  dom_e                   dom_q;
  logic [CFG_ADDR_W-1:0]  add_q;
  logic [CFG_DATA_W-1:0]  data_q;
  logic                   wrn_q;
  logic [CFG_DATA_W-1:0]  rdata_q;

  dom_e                   dom_in;
  logic [CFG_ADDR_W-1:0]  word_in;
  logic                   access;
  logic                   local_acc;
  logic                   remote_start;
  logic                   status_wr;
  logic                   ack_sel;
  logic [CFG_DATA_W-1:0]  rdata_sel;
  logic                   expire;
  logic [2:0]             to_flags;
  logic [CFG_DATA_W-1:0]  local_rdata;
  logic                   unused_paddr;

  assign unused_paddr = ^{PADDR[1:0], PADDR[APB_ADDR_WIDTH-1:9]};

  assign dom_in       = dom_e'(PADDR[8:7]);
  assign word_in      = PADDR[6:2];
  assign access       = PSEL && PENABLE;
  assign local_acc    = (state_q == ST_IDLE) && access && (dom_in == DOM_LOCAL);
  assign remote_start = (state_q == ST_IDLE) && access && (dom_in != DOM_LOCAL);
  assign status_wr    = local_acc && PWRITE && (word_in == LOC_STATUS);

  // Select ack and read data of the latched domain
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    unique case (dom_q)
      DOM_SOC:     begin ack_sel = soc_cfg_ack_i;     rdata_sel = soc_cfg_r_data_i;     end
      DOM_PER:     begin ack_sel = per_cfg_ack_i;     rdata_sel = per_cfg_r_data_i;     end
      DOM_CLUSTER: begin ack_sel = cluster_cfg_ack_i; rdata_sel = cluster_cfg_r_data_i; end
      default:     ;
    endcase
  end

`ifdef CLK_CFG_TIMEOUT_EN
  logic       err_q;
  logic [2:0] sticky_q;

  clk_cfg_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q != ST_REQ),
    .en_i     (state_q == ST_REQ),
    .expire_o (expire)
  );

  // Error flag for the current response and sticky per-domain timeout flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      sticky_q <= '0;
    end else begin
      if (state_q == ST_REQ) begin
        if (ack_sel) begin
          err_q <= 1'b0;
        end else if (expire) begin
          err_q    <= 1'b1;
          sticky_q <= sticky_q | (3'b001 << dom_q);
        end
      end
      if (status_wr) begin
        sticky_q <= sticky_q & ~PWDATA[5:3];
      end
    end
  end

  assign to_flags = sticky_q;
`else
  assign expire   = 1'b0;
  assign to_flags = '0;
`endif

  // Local register read mux
  always_comb begin
    local_rdata = '0;
    if (word_in == LOC_STATUS) begin
      local_rdata = pack_status(to_flags, {cluster_cfg_lock_i, per_cfg_lock_i, soc_cfg_lock_i});
    end else if (word_in == LOC_TIMEOUT) begin
`ifdef CLK_CFG_TIMEOUT_EN
      local_rdata = 32'(TIMEOUT_CYCLES);
`else
      local_rdata = '0;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, per-domain requests and APB response
  always_comb begin
    state_d           = state_q;
    soc_cfg_req_o     = 1'b0;
    per_cfg_req_o     = 1'b0;
    cluster_cfg_req_o = 1'b0;
    PREADY            = 1'b0;
    PRDATA            = '0;
    PSLVERR           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (remote_start) begin
          state_d = ST_REQ;
        end else if (local_acc) begin
          PREADY = 1'b1;
          PRDATA = local_rdata;
        end
      end
      ST_REQ: begin
        soc_cfg_req_o     = (dom_q == DOM_SOC);
        per_cfg_req_o     = (dom_q == DOM_PER);
        cluster_cfg_req_o = (dom_q == DOM_CLUSTER);
        if (ack_sel || expire) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        PREADY  = 1'b1;
        PRDATA  = rdata_q;
`ifdef CLK_CFG_TIMEOUT_EN
        PSLVERR = err_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the remote request and capture the response data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dom_q   <= DOM_SOC;
      add_q   <= '0;
      data_q  <= '0;
      wrn_q   <= CFG_WRN_READ;
      rdata_q <= '0;
    end else begin
      if (remote_start) begin
        dom_q  <= dom_in;
        add_q  <= word_in;
        data_q <= PWDATA;
        wrn_q  <= ~PWRITE;
      end
      if (state_q == ST_REQ) begin
        if (ack_sel) begin
          rdata_q <= (wrn_q == CFG_WRN_READ) ? rdata_sel : '0;
        end else if (expire) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign soc_cfg_add_o      = add_q;
  assign per_cfg_add_o      = add_q;
  assign cluster_cfg_add_o  = add_q;
  assign soc_cfg_data_o     = data_q;
  assign per_cfg_data_o     = data_q;
  assign cluster_cfg_data_o = data_q;
  assign soc_cfg_wrn_o      = wrn_q;
  assign per_cfg_wrn_o      = wrn_q;
  assign cluster_cfg_wrn_o  = wrn_q;

endmodule

// File: tb/tb_clk_cfg_initiator.sv
// Self-checking bench for clk_cfg_initiator: APB master, per-domain responders
// with programmable ack delay, and a transaction-level expectation model.
module tb_clk_cfg_initiator;

  localparam int unsigned T = 16;
`ifdef CLK_CFG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic        soc_req, per_req, cl_req;
  logic        soc_ack, per_ack, cl_ack;
  logic        soc_lock, per_lock, cl_lock;
  logic [4:0]  soc_add, per_add, cl_add;
  logic [31:0] soc_data, per_data, cl_data;
  logic        soc_wrn, per_wrn, cl_wrn;

  logic [31:0] rd [3];
  int unsigned delay;
  int unsigned rc;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic        mon_active;
  logic [1:0]  exp_dom;
  logic [4:0]  exp_add;
  logic [31:0] exp_data;
  logic        exp_wrn;
  int unsigned req_seen;
  logic [2:0]  sticky;

  clk_cfg_initiator #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .PADDR                (PADDR),
    .PWDATA               (PWDATA),
    .PWRITE               (PWRITE),
    .PSEL                 (PSEL),
    .PENABLE              (PENABLE),
    .PRDATA               (PRDATA),
    .PREADY               (PREADY),
    .PSLVERR              (PSLVERR),
    .soc_cfg_req_o        (soc_req),
    .soc_cfg_ack_i        (soc_ack),
    .soc_cfg_lock_i       (soc_lock),
    .soc_cfg_r_data_i     (rd[0]),
    .soc_cfg_add_o        (soc_add),
    .soc_cfg_data_o       (soc_data),
    .soc_cfg_wrn_o        (soc_wrn),
    .per_cfg_req_o        (per_req),
    .per_cfg_ack_i        (per_ack),
    .per_cfg_lock_i       (per_lock),
    .per_cfg_r_data_i     (rd[1]),
    .per_cfg_add_o        (per_add),
    .per_cfg_data_o       (per_data),
    .per_cfg_wrn_o        (per_wrn),
    .cluster_cfg_req_o    (cl_req),
    .cluster_cfg_ack_i    (cl_ack),
    .cluster_cfg_lock_i   (cl_lock),
    .cluster_cfg_r_data_i (rd[2]),
    .cluster_cfg_add_o    (cl_add),
    .cluster_cfg_data_o   (cl_data),
    .cluster_cfg_wrn_o    (cl_wrn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: ack (combinational from req) once req has been high 'delay' cycles
  always @(posedge clk) begin
    if (!rst_n || !(soc_req || per_req || cl_req)) rc <= 0;
    else rc <= rc + 1;
  end
  assign soc_ack = soc_req && (rc >= delay);
  assign per_ack = per_req && (rc >= delay);
  assign cl_ack  = cl_req  && (rc >= delay);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Per-cycle compare: while any req is high it must be the expected domain
  // alone, with the broadcast add/data/wrn equal to the issued access.
  always @(negedge clk) begin
    if (rst_n && (soc_req || per_req || cl_req)) begin
      chk("req_onehot", 32'({cl_req, per_req, soc_req}),
          mon_active ? 32'(3'b001 << exp_dom) : 32'd0);
      chk("cfg_add", 32'({soc_add, per_add, cl_add}), 32'({3{exp_add}}));
      chk("cfg_data_soc", soc_data, exp_data);
      chk("cfg_data_per", per_data, exp_data);
      chk("cfg_data_cluster", cl_data, exp_data);
      chk("cfg_wrn", 32'({soc_wrn, per_wrn, cl_wrn}), 32'({3{exp_wrn}}));
      req_seen++;
    end
  end

  // One APB transfer plus the model's expectation for it
  task automatic xfer(input logic [11:0] addr, input logic write, input logic [31:0] wdata,
                      input int unsigned dly, input logic [31:0] resp,
                      output logic [31:0] got, output logic gerr,
                      output int unsigned cyc, output int unsigned nreq);
    logic [1:0]  dom;
    logic [4:0]  word;
    logic [31:0] e_data;
    int unsigned e_cyc, e_req;
    logic        e_err, timeout, done;
    dom  = addr[8:7];
    word = addr[6:2];
    got  = '0;
    gerr = 1'b0;
    if (dom == 2'd3) begin
      e_cyc = 1; e_req = 0; e_err = 1'b0;
      if (word == 5'd0)      e_data = {26'b0, sticky, cl_lock, per_lock, soc_lock};
      else if (word == 5'd1) e_data = TO_EN ? 32'(T) : 32'd0;
      else                   e_data = 32'd0;
      mon_active = 1'b0;
    end else begin
      timeout = TO_EN && (dly >= T);
      e_req   = timeout ? T : dly + 1;
      e_cyc   = e_req + 2;
      e_err   = timeout;
      e_data  = (timeout || write) ? 32'd0 : resp;
      rd[dom] = resp;
      exp_dom = dom; exp_add = word; exp_data = wdata; exp_wrn = ~write;
      mon_active = 1'b1;
    end
    delay    = dly;
    req_seen = 0;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = write; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (PREADY) begin
        got = PRDATA; gerr = PSLVERR; done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    if (done) @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    nreq = req_seen;
    mon_active = 1'b0;
    chk("ready_seen", 32'(done), 32'd1);
    chk("access_cycles", cyc, e_cyc);
    chk("req_cycles", nreq, e_req);
    chk("pslverr", 32'(gerr), 32'(e_err));
    if (!write || dom != 2'd3) chk("prdata", got, e_data);
    if (dom == 2'd3 && write && word == 5'd0) sticky = sticky & ~wdata[5:3];
    if (dom != 2'd3 && TO_EN && dly >= T) sticky[dom] = 1'b1;
  endtask

  logic [31:0] got;
  logic        gerr;
  int unsigned cyc, nreq;

  initial begin
    rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; delay = 0;
    rd[0] = '0; rd[1] = '0; rd[2] = '0;
    soc_lock = 1'b0; per_lock = 1'b0; cl_lock = 1'b0;
    mon_active = 1'b0; exp_dom = '0; exp_add = '0; exp_data = '0; exp_wrn = 1'b1;
    req_seen = 0; sticky = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'({cl_req, per_req, soc_req}), 32'd0);
    chk("rst_add", 32'(soc_add), 32'd0);
    chk("rst_data", soc_data, 32'd0);
    chk("rst_wrn", 32'({soc_wrn, per_wrn, cl_wrn}), 32'h7);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    xfer(12'h000, 1'b0, 32'h0, 0, 32'h00010001, got, gerr, cyc, nreq);
    chk("pin_soc_rdata", got, 32'h00010001);
    chk("pin_soc_cycles", cyc, 32'd3);
    chk("pin_soc_req", nreq, 32'd1);

    xfer(12'h08C, 1'b0, 32'h0, 0, 32'hFFFDFFFC, got, gerr, cyc, nreq);
    chk("pin_per_rdata", got, 32'hFFFDFFFC);

    xfer(12'h114, 1'b1, 32'h12345678, 4, 32'hDEADBEEF, got, gerr, cyc, nreq);
    chk("pin_cl_wr_req", nreq, 32'd5);
    chk("pin_cl_wr_rdata", got, 32'd0);
    chk("pin_cl_wr_err", 32'(gerr), 32'd0);

    soc_lock = 1'b1; per_lock = 1'b0; cl_lock = 1'b1;
    xfer(12'h180, 1'b0, 32'h0, 0, 32'h0, got, gerr, cyc, nreq);
    chk("pin_status_locks", got, 32'h00000005);
    chk("pin_status_cycles", cyc, 32'd1);

`ifdef CLK_CFG_TIMEOUT_EN
    xfer(12'h000, 1'b0, 32'h0, 1000, 32'hAAAA5555, got, gerr, cyc, nreq);
    chk("pin_to_req", nreq, 32'd16);
    chk("pin_to_err", 32'(gerr), 32'd1);
    chk("pin_to_rdata", got, 32'd0);
    xfer(12'h180, 1'b0, 32'h0, 0, 32'h0, got, gerr, cyc, nreq);
    chk("pin_to_sticky_set", 32'(got[3]), 32'd1);
    xfer(12'h180, 1'b1, 32'h8, 0, 32'h0, got, gerr, cyc, nreq);
    xfer(12'h180, 1'b0, 32'h0, 0, 32'h0, got, gerr, cyc, nreq);
    chk("pin_to_sticky_clr", 32'(got[3]), 32'd0);
    xfer(12'h184, 1'b0, 32'h0, 0, 32'h0, got, gerr, cyc, nreq);
    chk("pin_timeout_const", got, 32'd16);
    xfer(12'h000, 1'b0, 32'h0, T - 1, 32'h0BADF00D, got, gerr, cyc, nreq);
    chk("pin_ack_wins_req", nreq, 32'd16);
    chk("pin_ack_wins_err", 32'(gerr), 32'd0);
    chk("pin_ack_wins_rdata", got, 32'h0BADF00D);
`else
    xfer(12'h184, 1'b0, 32'h0, 0, 32'h0, got, gerr, cyc, nreq);
    chk("pin_timeout_const", got, 32'd0);
`endif

    // Reset in the middle of a cluster request
    delay = 1000; exp_dom = 2'd2; exp_add = 5'd0; exp_data = 32'h0; exp_wrn = 1'b1;
    mon_active = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h100; PWRITE = 1'b0; PWDATA = 32'h0;
    @(posedge clk); #1 PENABLE = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'({cl_req, per_req, soc_req}), 32'd0);
    chk("rst_mid_pready", 32'(PREADY), 32'd0);
    chk("rst_mid_wrn", 32'(cl_wrn), 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0; mon_active = 1'b0; sticky = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    xfer(12'h000, 1'b0, 32'h0, 1, 32'h5A5A0F0F, got, gerr, cyc, nreq);
    chk("pin_post_rst_rdata", got, 32'h5A5A0F0F);

    // Randomized traffic over all domains
    for (int i = 0; i < 200; i++) begin
      logic [11:0] a;
      int unsigned d;
      a = 12'($urandom);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 4) : $urandom_range(0, 5);
      {cl_lock, per_lock, soc_lock} = 3'($urandom);
      xfer(a, 1'($urandom), $urandom, d, $urandom, got, gerr, cyc, nreq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_cfg_initiator.md
Name: clk_cfg_initiator

Overview:
- APB slave that converts CPU register accesses into req/ack transactions on the three clock-generator config ports (soc, per, cluster).
- Initiator-side counterpart of the clock generator's cfg responder.
- Sits in the SoC peripheral subsystem between the APB interconnect and the clock generator.
- Adds a per-domain ack timeout and a local status register holding lock inputs and sticky error flags.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width; only PADDR[8:2] decoded, upper bits ignored.
- TIMEOUT_CYCLES, 256, max cycles req held without ack before abort; legal range 2..65535.

Ports:
- clk_i  input  1  single clock
- rst_ni  input  1  asynchronous active-low reset
- PADDR  input  APB_ADDR_WIDTH  APB address; [8:7] domain (0 soc, 1 per, 2 cluster, 3 local), [6:2] cfg word address
- PWDATA  input  32  APB write data
- PWRITE  input  1  APB write
- PSEL  input  1  APB select
- PENABLE  input  1  APB enable
- PRDATA  output  32  APB read data
- PREADY  output  1  APB ready
- PSLVERR  output  1  APB error
- {soc,per,cluster}_cfg_req_o  output  1 each  per-domain request
- {soc,per,cluster}_cfg_ack_i  input  1 each  per-domain ack (may be combinational from req)
- {soc,per,cluster}_cfg_lock_i  input  1 each  domain lock status
- {soc,per,cluster}_cfg_r_data_i  input  32 each  responder read data
- {soc,per,cluster}_cfg_add_o  output  5 each  shared registered address, broadcast
- {soc,per,cluster}_cfg_data_o  output  32 each  shared registered write data, broadcast
- {soc,per,cluster}_cfg_wrn_o  output  1 each  shared registered flag; 0 = write, 1 = read

Behaviour:
- Reset values:
  - all req_o = 0, add_o = 0, data_o = 0, wrn_o = 1.
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - FSM = IDLE, sticky flags = 0, timeout counter = 0.
- Local space (PADDR[8:7]=3) is zero-wait: PREADY=1 combinationally in the access phase, PSLVERR=0.
  - Offset 0x0 read: {26'b0, to_cluster, to_per, to_soc, cluster_lock, per_lock, soc_lock}.
  - Offset 0x0 write: bits [5:3] are write-1-to-clear.
  - Offset 0x4 read: TIMEOUT_CYCLES as a constant.
  - Other offsets read 0; writes to them are ignored.
- Remote FSM states: IDLE, REQ, RESP.
  - IDLE: on PSEL&PENABLE with domain<3, register add=PADDR[6:2], data=PWDATA, wrn=~PWRITE and latch domain; go to REQ. PREADY=0.
  - REQ: selected req_o=1, all others 0. The counter increments each cycle.
    - Ack sampled high: capture r_data_i (reads only; writes capture 0), clear err, go to RESP.
    - Counter reaches TIMEOUT_CYCLES-1 with no ack: set sticky to_<domain>, err=1, captured data=0, go to RESP.
    - Ack and timeout in the same cycle: ack wins.
  - RESP: req_o=0, PREADY=1, PRDATA=captured data, PSLVERR=err. Next state IDLE; counter cleared.
- Latency: a remote access with ack in the first REQ cycle completes with PREADY in the 3rd access-phase cycle. req is high for exactly one cycle in that case.
- Req is never asserted in two consecutive transactions without an intervening low cycle.
- add/data/wrn are stable for the whole time req is high.
- Lock low does not block requests; it is only reported.
- Reset mid-operation: req drops immediately (async), FSM returns to IDLE, and the pending APB transfer is abandoned.
- PSEL dropping mid-transfer is a protocol violation; the FSM still completes RESP and then returns to IDLE.

Optional Feature:
- Macro: CLK_CFG_TIMEOUT_EN.
- Defined: timeout counter, to_* sticky flags and PSLVERR generation exist as described.
- Undefined:
  - REQ waits indefinitely for ack; PSLVERR is tied to 0.
  - Status bits [5:3] read 0.
  - Offset 0x4 reads 0.
  - The counter logic is not instantiated.

Decomposition:
- Package clk_cfg_pkg:
  - domain enum (DOM_SOC, DOM_PER, DOM_CLUSTER, DOM_LOCAL).
  - FSM state enum.
  - local register offsets.
  - constants CFG_WRN_WRITE=0 and CFG_WRN_READ=1.
  - cfg address width 5 and data width 32.
- Sub-module clk_cfg_timeout_cnt: counter with clear, enable and expire outputs, width $clog2(TIMEOUT_CYCLES). Instantiated only under CLK_CFG_TIMEOUT_EN.

Test Plan:
- Read soc word 0 (PADDR 0x000), responder ack combinational returning 0x00010001 → soc_cfg_req_o high 1 cycle, add=0, wrn=1; PRDATA=0x00010001, PSLVERR=0, PREADY in access cycle 3.
- Read per word 3 (PADDR 0x08C), per responder returns 0xFFFDFFFC → only per_cfg_req_o toggles; PRDATA=0xFFFDFFFC.
- Write cluster word 5 (PADDR 0x114, PWDATA 0x12345678), ack delayed 4 cycles → cluster_cfg_data_o=0x12345678, add=5, wrn=0, held stable for 5 req cycles; PRDATA=0, PSLVERR=0.
- TIMEOUT_CYCLES=16, soc ack tied 0, read PADDR 0x000:
  - req high exactly 16 cycles; PSLVERR=1, PRDATA=0.
  - Status read at PADDR 0x180 → bit3=1.
  - Write 0x8 to 0x180 → bit3=0.
- Locks soc=1, per=0, cluster=1; read PADDR 0x180 → 0x00000005, PREADY in first access cycle.
- Assert rst_ni low during REQ of a cluster access → cluster_cfg_req_o=0 immediately; after release, a new soc read completes normally.
